// File: rtl/pipe_reg_chain.sv
// Multi-stage pipeline register with per-stage valid bits and valid/ready back-pressure.
// Define PIPE_OCC_EN to build the registered occupancy port and its counter.
module pipe_reg_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [DEPTH-1:0][WIDTH-1:0] dat_q, dat_d;
  logic [DEPTH-1:0]            mv;   // stage i hands its word downstream this cycle
  logic [DEPTH-1:0]            ok;   // stage i may load this cycle
  logic                        rdy;
  logic                        acc;

  always_comb begin
    mv = '0;
    ok = '0;
    // Ready ripples back from out_ready, output stage first, so empty stages absorb bubbles.
    mv[DEPTH-1] = vld_q[DEPTH-1] & out_ready;
    ok[DEPTH-1] = ~vld_q[DEPTH-1] | mv[DEPTH-1];
    for (int i = DEPTH-2; i >= 0; i--) begin
      mv[i] = vld_q[i] & ok[i+1];
      ok[i] = ~vld_q[i] | mv[i];
    end
    rdy = ~rst & ~flush & ok[0];
    acc = in_valid & rdy;

    vld_d = vld_q;
    dat_d = dat_q;
    if (acc) begin
      vld_d[0] = 1'b1;
      dat_d[0] = in_data;
    end else if (mv[0]) begin
      vld_d[0] = 1'b0;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (mv[i-1]) begin
        vld_d[i] = 1'b1;
        dat_d[i] = dat_q[i-1];
      end else if (mv[i]) begin
        vld_d[i] = 1'b0;
      end
    end
    // Flush drops every word but leaves the data registers untouched.
    if (flush) begin
      vld_d = '0;
      dat_d = dat_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign in_ready  = rdy;
  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];

`ifdef PIPE_OCC_EN
  localparam int OW = $clog2(DEPTH+1);
  logic [OW-1:0] occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    if (flush)
      occ_d = '0;
    else if (acc && !mv[DEPTH-1])
      occ_d = occ_q + OW'(1);
    else if (!acc && mv[DEPTH-1])
      occ_d = occ_q - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occupancy = occ_q;

  a_occ_popcount: assert property (@(posedge clk) disable iff (rst)
    occ_q == OW'($countones(vld_q)));
`endif

endmodule
